// File: rtl/arrhythmia_stats_readout.sv
// rtl/arrhythmia_stats_readout.sv - snapshot + 14-byte framed readout of arrhythmia classifier statistics
// Captures total/tachy/normal/brady counters and the last beat interval atomically on start,
// then streams HDR, seq, counters (MSB first), 24-bit interval and an XOR checksum over a
// byte-wide valid/ready port. Optionally strobes clr_pulse to the classifier afterwards.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, clear_after          frame request and post-frame clear option (honoured in IDLE)
//   clear_req                   standalone clear request (honoured in IDLE)
//   total_beats .. brady_count  classifier counters, COUNT_W bits each
//   last_interval_ms            classifier last interval, MS_W bits
//   out_byte, out_valid         frame byte stream; out_ready accepts
//   busy                        high while sending or clearing
//   frame_done, clr_pulse       one-cycle completion and clear strobes
module arrhythmia_stats_readout #(
  parameter int          COUNT_W  = 16,
  parameter int          MS_W     = 20,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear_after,
  input  logic               clear_req,
  input  logic [COUNT_W-1:0] total_beats,
  input  logic [COUNT_W-1:0] tachy_count,
  input  logic [COUNT_W-1:0] normal_count,
  input  logic [COUNT_W-1:0] brady_count,
  input  logic [MS_W-1:0]    last_interval_ms,
  output logic [7:0]         out_byte,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               frame_done,
  output logic               clr_pulse
);

  typedef enum logic [1:0] {IDLE, SEND, CLEAR} state_t;

  localparam logic [3:0] LAST_IDX = 4'd13;

  state_t      state, state_nxt;
  logic [3:0]  idx;
  logic [7:0]  seq;
  logic [7:0]  csum;
  logic        clr_flag;
  logic [15:0] snap_total, snap_tachy, snap_normal, snap_brady;
  logic [23:0] snap_ms;

  logic        accept;
  logic        xfer;
  logic        last_xfer;
  logic [3:0]  nidx;
  logic [7:0]  next_byte;

  assign accept    = (state == IDLE) && start;
  assign xfer      = (state == SEND) && out_valid && out_ready;
  assign last_xfer = xfer && (idx == LAST_IDX);
  assign nidx      = idx + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start)          state_nxt = SEND;
        else if (clear_req) state_nxt = CLEAR;
      end
      SEND: begin
        if (last_xfer) state_nxt = clr_flag ? CLEAR : IDLE;
      end
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // out_byte is registered, so the byte for idx+1 is prepared from the snapshot
  // while idx is being transferred. The checksum byte folds in the byte now leaving.
  always_comb begin
    next_byte = HDR_BYTE;
    case (nidx)
      4'd1:    next_byte = seq;
      4'd2:    next_byte = snap_total[15:8];
      4'd3:    next_byte = snap_total[7:0];
      4'd4:    next_byte = snap_tachy[15:8];
      4'd5:    next_byte = snap_tachy[7:0];
      4'd6:    next_byte = snap_normal[15:8];
      4'd7:    next_byte = snap_normal[7:0];
      4'd8:    next_byte = snap_brady[15:8];
      4'd9:    next_byte = snap_brady[7:0];
      4'd10:   next_byte = snap_ms[23:16];
      4'd11:   next_byte = snap_ms[15:8];
      4'd12:   next_byte = snap_ms[7:0];
      4'd13:   next_byte = csum ^ out_byte;
      default: next_byte = HDR_BYTE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= 4'd0;
      seq         <= 8'd0;
      csum        <= 8'd0;
      clr_flag    <= 1'b0;
      snap_total  <= 16'd0;
      snap_tachy  <= 16'd0;
      snap_normal <= 16'd0;
      snap_brady  <= 16'd0;
      snap_ms     <= 24'd0;
      out_byte    <= 8'd0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      clr_pulse   <= 1'b0;
    end else begin
      frame_done <= last_xfer;
      clr_pulse  <= (state == CLEAR);
      busy       <= (state_nxt != IDLE);
      if (accept) begin
        snap_total  <= 16'(total_beats);
        snap_tachy  <= 16'(tachy_count);
        snap_normal <= 16'(normal_count);
        snap_brady  <= 16'(brady_count);
        snap_ms     <= 24'(last_interval_ms);
        clr_flag    <= clear_after | clear_req;
        idx         <= 4'd0;
        csum        <= 8'd0;
        out_byte    <= HDR_BYTE;
        out_valid   <= 1'b1;
      end else if (xfer) begin
        if (last_xfer) begin
          idx       <= 4'd0;
          seq       <= seq + 8'd1;
          out_valid <= 1'b0;
          out_byte  <= 8'd0;
        end else begin
          idx      <= nidx;
          csum     <= csum ^ out_byte;
          out_byte <= next_byte;
        end
      end
    end
  end

endmodule

// File: tb/tb_arrhythmia_stats_readout.sv
// tb/tb_arrhythmia_stats_readout.sv - directed self-checking bench for arrhythmia_stats_readout
module tb_arrhythmia_stats_readout;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear_after = 1'b0;
  logic        clear_req = 1'b0;
  logic [15:0] total_beats = '0;
  logic [15:0] tachy_count = '0;
  logic [15:0] normal_count = '0;
  logic [15:0] brady_count = '0;
  logic [19:0] last_interval_ms = '0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        frame_done;
  logic        clr_pulse;

  int checks = 0;
  int errors = 0;

  logic [7:0] cap [14];
  logic [7:0] exp_fr [14];
  logic [7:0] t2_bytes [14] = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h00, 8'h10, 8'h01,
                                8'h00, 8'h00, 8'h13, 8'h00, 8'h03, 8'hE8, 8'h6E};
  int cap_n;
  int stall_err;
  logic [7:0] exp_seq;

  always #5 clk = ~clk;

  arrhythmia_stats_readout dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_after(clear_after),
    .clear_req(clear_req), .total_beats(total_beats), .tachy_count(tachy_count),
    .normal_count(normal_count), .brady_count(brady_count),
    .last_interval_ms(last_interval_ms), .out_byte(out_byte), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done), .clr_pulse(clr_pulse)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [15:0] t, ty, n, b, input logic [19:0] ms);
    total_beats = t; tachy_count = ty; normal_count = n; brady_count = b;
    last_interval_ms = ms;
  endtask

  task automatic build_exp(input logic [7:0] s, input logic [15:0] t, ty, n, b,
                           input logic [19:0] ms);
    logic [23:0] m;
    logic [7:0]  x;
    m = {4'h0, ms};
    exp_fr[0] = 8'hA5;     exp_fr[1] = s;
    exp_fr[2] = t[15:8];   exp_fr[3] = t[7:0];
    exp_fr[4] = ty[15:8];  exp_fr[5] = ty[7:0];
    exp_fr[6] = n[15:8];   exp_fr[7] = n[7:0];
    exp_fr[8] = b[15:8];   exp_fr[9] = b[7:0];
    exp_fr[10] = m[23:16]; exp_fr[11] = m[15:8]; exp_fr[12] = m[7:0];
    x = 8'h00;
    for (int i = 0; i < 13; i++) x = x ^ exp_fr[i];
    exp_fr[13] = x;
  endtask

  task automatic pulse_start(input logic ca);
    start = 1'b1; clear_after = ca;
    step();
    start = 1'b0; clear_after = 1'b0;
  endtask

  // Collect up to 14 transfers; returns in the cycle after the last transfer.
  task automatic get_frame(input int rand_ready, input int scramble, input int max_xfers);
    logic       prev_stalled;
    logic [7:0] prev_byte;
    cap_n = 0; stall_err = 0; prev_stalled = 1'b0; prev_byte = 8'h00;
    for (int cyc = 0; cyc < 400 && cap_n < max_xfers; cyc++) begin
      if (prev_stalled && out_byte !== prev_byte) stall_err++;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (scramble) set_inputs(16'($urandom), 16'($urandom), 16'($urandom),
                               16'($urandom), 20'($urandom));
      if (out_valid && out_ready) begin
        cap[cap_n] = out_byte;
        cap_n++;
        prev_stalled = 1'b0;
      end else begin
        prev_stalled = out_valid;
      end
      prev_byte = out_byte;
      step();
    end
    out_ready = 1'b1;
    checks++;
    if (cap_n != max_xfers) begin
      errors++;
      $display("FAIL frame_timeout: got %0d bytes, required %0d", cap_n, max_xfers);
    end
  endtask

  task automatic compare_frame(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < 14; i++) if (bad < 0 && cap[i] !== exp_fr[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: byte %0d is %02h, required %02h", name, bad, cap[bad], exp_fr[bad]);
    end
  endtask

  task automatic check_end_of_frame(input string name, input logic exp_busy);
    checks++;
    if (frame_done !== 1'b1 || out_valid !== 1'b0 || busy !== exp_busy) begin
      errors++;
      $display("FAIL %s_end: frame_done=%b out_valid=%b busy=%b, required 1 0 %b",
               name, frame_done, out_valid, busy, exp_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 ||
        clr_pulse !== 1'b0 || out_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b clr=%b byte=%02h, required all 0",
               out_valid, busy, frame_done, clr_pulse, out_byte);
    end
    rst_n = 1'b1;
    exp_seq = 8'h00;
    step();
  endtask

  task automatic test_frame();
    set_inputs(16'h0123, 16'h0010, 16'h0100, 16'h0013, 20'h003E8);
    pulse_start(1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_byte !== 8'hA5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: valid=%b byte=%02h busy=%b, required 1 a5 1",
               out_valid, out_byte, busy);
    end
    get_frame(0, 0, 14);
    for (int i = 0; i < 14; i++) exp_fr[i] = t2_bytes[i];
    compare_frame("t2_frame");
    check_end_of_frame("t2", 1'b0);
    step();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL done_width: frame_done=%b, required 0", frame_done);
    end
    exp_seq++;
  endtask

  task automatic test_backpressure();
    set_inputs(16'h0123, 16'h0010, 16'h0100, 16'h0013, 20'h003E8);
    build_exp(exp_seq, 16'h0123, 16'h0010, 16'h0100, 16'h0013, 20'h003E8);
    pulse_start(1'b0);
    get_frame(1, 0, 14);
    compare_frame("backpressure_frame");
    checks++;
    if (stall_err != 0) begin
      errors++;
      $display("FAIL stall_stable: %0d changes while stalled, required 0", stall_err);
    end
    check_end_of_frame("backpressure", 1'b0);
    exp_seq++;
    step();
  endtask

  task automatic test_atomicity();
    set_inputs(16'hBEEF, 16'h1234, 16'h5678, 16'h9ABC, 20'hFEDCB);
    build_exp(exp_seq, 16'hBEEF, 16'h1234, 16'h5678, 16'h9ABC, 20'hFEDCB);
    pulse_start(1'b0);
    get_frame(1, 1, 14);
    compare_frame("atomic_frame");
    exp_seq++;
    step();
  endtask

  task automatic test_clear();
    int seen_valid;
    set_inputs(16'h0001, 16'h0002, 16'h0003, 16'h0004, 20'h00005);
    build_exp(exp_seq, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 20'h00005);
    pulse_start(1'b1);
    get_frame(0, 0, 14);
    compare_frame("clear_frame");
    exp_seq++;
    checks++;
    if (frame_done !== 1'b1 || clr_pulse !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_phase: done=%b clr=%b busy=%b, required 1 0 1",
               frame_done, clr_pulse, busy);
    end
    step();
    checks++;
    if (clr_pulse !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_after_frame: clr=%b done=%b busy=%b, required 1 0 0",
               clr_pulse, frame_done, busy);
    end
    step();
    checks++;
    if (clr_pulse !== 1'b0) begin
      errors++;
      $display("FAIL clr_width: clr=%b, required 0", clr_pulse);
    end
    // standalone clear request
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || clr_pulse !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_req_enter: busy=%b clr=%b valid=%b, required 1 0 0",
               busy, clr_pulse, out_valid);
    end
    step();
    checks++;
    if (clr_pulse !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_req_pulse: clr=%b valid=%b, required 1 0", clr_pulse, out_valid);
    end
    step();
    checks++;
    if (clr_pulse !== 1'b0) begin
      errors++;
      $display("FAIL clear_req_width: clr=%b, required 0", clr_pulse);
    end
    // start while sending must be ignored
    build_exp(exp_seq, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 20'h00005);
    pulse_start(1'b0);
    get_frame(0, 0, 3);
    start = 1'b1; clear_req = 1'b1;
    get_frame(0, 0, 11);
    start = 1'b0; clear_req = 1'b0;
    exp_seq++;
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1 || clr_pulse === 1'b1) seen_valid++;
      step();
    end
    checks++;
    if (seen_valid != 0) begin
      errors++;
      $display("FAIL start_ignored: %0d extra active cycles, required 0", seen_valid);
    end
  endtask

  task automatic test_mid_reset();
    set_inputs(16'h1111, 16'h2222, 16'h3333, 16'h4444, 20'h55555);
    pulse_start(1'b1);
    get_frame(0, 0, 5);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || clr_pulse !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b busy=%b clr=%b, required 0 0 0",
               out_valid, busy, clr_pulse);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (clr_pulse !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL no_partial_clear: clr=%b busy=%b, required 0 0", clr_pulse, busy);
    end
    exp_seq = 8'h00;
    build_exp(8'h00, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 20'h55555);
    pulse_start(1'b0);
    get_frame(0, 0, 14);
    compare_frame("post_reset_frame");
    exp_seq++;
    step();
  endtask

  task automatic test_back_to_back_seq_wrap();
    logic [15:0] t;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int f = 0; f < 257; f++) begin
      t = 16'(f * 16'h0107);
      set_inputs(t, ~t, t ^ 16'h5A5A, 16'(f), 20'(f * 20'h00371));
      build_exp(8'(f), t, ~t, t ^ 16'h5A5A, 16'(f), 20'(f * 20'h00371));
      pulse_start(1'b0);
      get_frame(0, 0, 14);
      compare_frame("wrap_frame");
      // start is raised in the frame_done cycle: first IDLE cycle
    end
    checks++;
    if (cap[1] !== 8'h00) begin
      errors++;
      $display("FAIL seq_wrap: seq byte %02h, required 00", cap[1]);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_atomicity();
    test_clear();
    test_mid_reset();
    test_back_to_back_seq_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
